div_unit: RTL

//  Multi-cycle 32-bit divider. Executes DIV on operands from the A/B registers.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic           trial_ok;

    // The shifted remainder needs WIDTH+1 bits because the divisor magnitude
    // may use the full WIDTH bits (e.g. 2^31 or unsigned operands).
    always_comb begin
        rem_sh   = {rem_i, quo_i[WIDTH-1]};
        trial_ok = (rem_sh >= {1'b0, divisor_i});
        if (trial_ok) begin
            rem_o = WIDTH'(rem_sh - {1'b0, divisor_i});
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule : div_step

// File: rtl/div_unit.sv
// Multi-cycle signed divider (HI = remainder, LO = quotient), one quotient bit per clock.
// Optional DIV_UNSIGNED_EN adds an is_unsigned input selecting DIVU behaviour.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = (CNT_W > $clog2(WIDTH) + 1) ? CNT_W : $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic             uns;

`ifdef DIV_UNSIGNED_EN
    assign uns = is_unsigned;
`else
    assign uns = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(WIDTH);
                        rem_d   = '0;
                        // Unary minus at WIDTH bits keeps |0x80000000| = 2^31 exact.
                        quo_d   = (!uns && dividend[WIDTH-1]) ? -dividend : dividend;
                        dvs_d   = (!uns && divisor[WIDTH-1])  ? -divisor  : divisor;
                        qneg_d  = !uns && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_d  = !uns && dividend[WIDTH-1];
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                lo_d    = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule : div_unit
